iob_fifo_reader: RTL and testbench

//  Read-side engine for the iob_fifo_sync / iob_fifo_async read port. Pops words from the

---
 rtl/iob_fifo_reader_pkg.sv | 19 +
 rtl/iob_skid_buf2.sv | 57 +++++
 rtl/iob_fifo_reader.sv | 64 ++++++
 tb/tb_iob_fifo_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_fifo_reader_pkg.sv
// Shared constants and the credit helper for the iob FIFO read-side engine.
package iob_fifo_reader_pkg;

  // Prefetch buffer depth and the widths derived from it
  localparam int unsigned IOB_FIFO_RD_DEPTH = 2;
  localparam int unsigned OCC_W             = 2;
  localparam int unsigned CRED_W            = 3;

  // True when one more FIFO read can be issued without overrunning the buffer:
  // words already buffered plus the read in flight, minus the word leaving now.
  function automatic logic credit_ok(input logic [OCC_W-1:0] occ,
                                     input logic             inflight,
                                     input logic             pop);
    logic [CRED_W-1:0] w_sum;
    w_sum = CRED_W'(occ) + CRED_W'(inflight) - CRED_W'(pop);
    return (w_sum < CRED_W'(IOB_FIFO_RD_DEPTH));
  endfunction

endpackage

// File: rtl/iob_skid_buf2.sv
// Two-entry register FIFO: head is entry 0, tail writes land behind it.
module iob_skid_buf2
  import iob_fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_head,
  output logic [OCC_W-1:0]  o_occ
);

  logic [DATA_W-1:0] r_mem0;
  logic [DATA_W-1:0] r_mem1;
  logic [OCC_W-1:0]  r_occ;

  // Storage and occupancy; flush empties the buffer and overrides any push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_occ  <= '0;
    end else if (i_flush) begin
      r_occ <= '0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == OCC_W'(0)) r_mem0 <= i_wdata;
          else                    r_mem1 <= i_wdata;
          r_occ <= r_occ + OCC_W'(1);
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_occ  <= r_occ - OCC_W'(1);
        end
        2'b11: begin
          // head leaves; the new word lands directly behind whatever remains
          if (r_occ == OCC_W'(IOB_FIFO_RD_DEPTH)) begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_wdata;
          end else begin
            r_mem0 <= i_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head = r_mem0;
  assign o_occ  = r_occ;

endmodule

// File: rtl/iob_fifo_reader.sv
// Pops an iob FIFO read port (1-cycle latency) and re-presents it as a
// valid/ready stream with 2-word prefetch for full throughput.
module iob_fifo_reader
  import iob_fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  output logic              r_en,
  input  logic [DATA_W-1:0] r_data,
  input  logic              r_empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  word_cnt
);

  logic             r_inflight;
  logic [CNT_W-1:0] r_word_cnt;
  logic             w_pop;
  logic             w_write;
  logic [OCC_W-1:0] w_occ;

  assign w_pop   = m_valid & m_ready;
  // a returning word is dropped if a flush lands in its arrival cycle
  assign w_write = r_inflight & ~flush;

  // FIFO pop request, gated by reset, flush, empty and buffer credit
  assign r_en = rst_n & ~flush & ~r_empty & credit_ok(w_occ, r_inflight, w_pop);

  // Remember that a read was issued so its data is captured next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inflight <= 1'b0;
    else        r_inflight <= r_en;
  end

  // Delivered-word counter; pops coinciding with a flush are not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_word_cnt <= '0;
    else if (w_pop & ~flush) r_word_cnt <= r_word_cnt + CNT_W'(1);
  end

  iob_skid_buf2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_write),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_wdata (r_data),
    .o_head  (m_data),
    .o_occ   (w_occ)
  );

  assign m_valid   = (w_occ != OCC_W'(0));
  assign occupancy = w_occ;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_iob_fifo_reader.sv
// Bench for iob_fifo_reader: FIFO model with 1-cycle read latency and a
// pending-word scoreboard that tracks every word popped but not yet delivered.
module tb_iob_fifo_reader;

  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 4;
  localparam int          MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          r_en;
  logic [DW-1:0] r_data;
  logic          r_empty;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] word_cnt;

  always #5 clk = ~clk;

  iob_fifo_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .r_en      (r_en),
    .r_data    (r_data),
    .r_empty   (r_empty),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy),
    .word_cnt  (word_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // FIFO contents, words popped but undelivered (with pop cycle), delivery log
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pend_q[$];
  int            pend_cyc[$];
  logic [DW-1:0] dlv_q[$];
  int            hs_cyc[$];
  int            cyc       = 0;
  int            exp_cnt   = 0;
  int            delivered = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          s_ren, s_valid;
  logic [DW-1:0] s_data;
  logic [1:0]    s_occ;
  logic [CW-1:0] s_cnt;

  // One clock: drive at negedge, check against the model, advance model and FIFO
  task automatic step(input logic rdy, input logic stall, input logic fl);
    int            arrived;
    logic          exp_pop;
    logic          exp_ren;
    logic          has_word;
    logic [DW-1:0] word;
    m_ready = rdy;
    flush   = fl;
    r_empty = stall || (fifo_q.size() == 0);
    #1;
    // a word popped in cycle c is visible from cycle c+2
    arrived = 0;
    foreach (pend_cyc[i]) if (pend_cyc[i] <= cyc - 2) arrived++;
    check("occupancy", 32'(occupancy), 32'(arrived));
    check("occ_le2", 32'(occupancy <= 2'd2), 32'd1);
    check("m_valid", 32'(m_valid), 32'(arrived != 0));
    if (arrived != 0) check("m_data_order", 32'(m_data), 32'(pend_q[0]));
    if (prev_stall) begin
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_data", 32'(m_data), 32'(prev_data));
    end
    check("word_cnt", 32'(word_cnt), 32'(exp_cnt));
    exp_pop = (arrived != 0) && rdy;
    exp_ren = !r_empty && !fl && ((pend_q.size() - (exp_pop ? 1 : 0)) < 2);
    check("r_en", 32'(r_en), 32'(exp_ren));
    s_ren = r_en; s_valid = m_valid; s_data = m_data; s_occ = occupancy; s_cnt = word_cnt;
    prev_stall = m_valid && !rdy && !fl;
    prev_data  = m_data;
    if (fl) begin
      pend_q.delete();
      pend_cyc.delete();
    end else if (exp_pop) begin
      dlv_q.push_back(m_data);
      void'(pend_q.pop_front());
      void'(pend_cyc.pop_front());
      exp_cnt = (exp_cnt + 1) % MOD;
      hs_cyc.push_back(cyc);
      delivered++;
    end
    has_word = 1'b0;
    word     = '0;
    if (r_en && !r_empty) begin
      word = fifo_q.pop_front();
      pend_q.push_back(word);
      pend_cyc.push_back(cyc);
      has_word = 1'b1;
    end
    @(posedge clk);
    #1;
    r_data = has_word ? word : DW'($urandom);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int start;
    int base;
    int cnt_before;
    logic [DW-1:0] nxt;

    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; r_empty = 1'b1; r_data = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_cnt", 32'(word_cnt), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_ren", 32'(r_en), 32'd0);
    rst_n = 1'b1;

    // Full-rate stream of 16 words from a preloaded FIFO
    for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(i));
    start = cyc; hs_cyc.delete(); dlv_q.delete();
    repeat (20) step(1'b1, 1'b0, 1'b0);
    check("stream_count", 32'(hs_cyc.size()), 32'd16);
    if (hs_cyc.size() == 16) begin
      check("stream_first", 32'(hs_cyc[0] - start), 32'd2);
      check("stream_span", 32'(hs_cyc[15] - hs_cyc[0]), 32'd15);
      for (int i = 0; i < 16; i++) check("stream_data", 32'(dlv_q[i]), 32'(i));
    end
    check("stream_wrap_cnt", 32'(s_cnt), 32'd0);

    // Backpressure: buffer fills to two, reads stop, head holds word 0
    for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(i));
    repeat (5) step(1'b0, 1'b0, 1'b0);
    check("bp_occ", 32'(s_occ), 32'd2);
    check("bp_ren", 32'(s_ren), 32'd0);
    check("bp_data", 32'(s_data), 32'd0);
    hs_cyc.delete(); dlv_q.delete();
    repeat (12) step(1'b1, 1'b0, 1'b0);
    check("bp_count", 32'(hs_cyc.size()), 32'd10);
    if (hs_cyc.size() == 10) begin
      check("bp_span", 32'(hs_cyc[9] - hs_cyc[0]), 32'd9);
      for (int i = 0; i < 10; i++) check("bp_drain_data", 32'(dlv_q[i]), 32'(i));
    end

    // Asynchronous reset mid-transfer with the FIFO still holding data
    for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(8'hA0 + i));
    repeat (3) step(1'b0, 1'b0, 1'b0);
    r_empty = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(m_valid), 32'd0);
    check("arst_ren", 32'(r_en), 32'd0);
    check("arst_cnt", 32'(word_cnt), 32'd0);
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_data", 32'(m_data), 32'd0);
    fifo_q.delete(); pend_q.delete(); pend_cyc.delete();
    exp_cnt = 0; prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;

    // Underflow: three words drain, then a late word appears two cycles after empty falls
    for (int i = 0; i < 3; i++) fifo_q.push_back(DW'(8'h30 + i));
    dlv_q.delete();
    repeat (8) step(1'b1, 1'b0, 1'b0);
    check("empty_count", 32'(dlv_q.size()), 32'd3);
    check("empty_valid", 32'(s_valid), 32'd0);
    check("empty_ren", 32'(s_ren), 32'd0);
    fifo_q.push_back(8'h55);
    step(1'b0, 1'b0, 1'b0);
    check("refill_ren", 32'(s_ren), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("refill_valid_early", 32'(s_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("refill_valid", 32'(s_valid), 32'd1);
    check("refill_data", 32'(s_data), 32'h55);
    step(1'b1, 1'b0, 1'b0);

    // Flush while streaming (pop in the flush cycle is not counted)
    for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(8'h80 + i));
    repeat (4) step(1'b1, 1'b0, 1'b0);
    nxt = fifo_q[0];
    cnt_before = exp_cnt;
    step(1'b1, 1'b0, 1'b1);
    check("flush_ren", 32'(s_ren), 32'd0);
    dlv_q.delete();
    step(1'b1, 1'b0, 1'b0);
    check("flush_occ", 32'(s_occ), 32'd0);
    check("flush_valid", 32'(s_valid), 32'd0);
    check("flush_cnt", 32'(s_cnt), 32'(cnt_before));
    repeat (4) step(1'b1, 1'b0, 1'b0);
    check("flush_next_count", 32'(dlv_q.size() > 0), 32'd1);
    if (dlv_q.size() > 0) check("flush_next_word", 32'(dlv_q[0]), 32'(nxt));

    // Flush while backpressured with a full buffer
    repeat (4) step(1'b0, 1'b0, 1'b0);
    nxt = fifo_q[0];
    step(1'b0, 1'b0, 1'b1);
    dlv_q.delete();
    repeat (5) step(1'b1, 1'b0, 1'b0);
    check("flush_bp_count", 32'(dlv_q.size() > 0), 32'd1);
    if (dlv_q.size() > 0) check("flush_bp_next", 32'(dlv_q[0]), 32'(nxt));

    // Random ready / FIFO stalls / rare flushes until 1000 more words delivered
    base  = delivered;
    start = cyc;
    while ((delivered - base) < 1000 && (cyc - start) < 20000) begin
      if (fifo_q.size() < 4) fifo_q.push_back(DW'($urandom));
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 99) == 0));
    end
    check("random_done", 32'((delivered - base) >= 1000), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
